// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Turns raw, bouncing, active-low push-buttons into clean per-key signals.
// Each key is an independent, identical channel:
//   2-flop synchronizer -> debounce counter -> debounced level
//   -> press/release strobes.
// The press strobe can optionally be followed by hold-to-repeat strobes.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   undefined : a held key produces exactly one pulse; no repeat logic exists.
//   defined   : a per-key repeat FSM (IDLE/DELAY/REPEAT) adds pulses
//               REPEAT_DELAY cycles after the press pulse, then one pulse every
//               REPEAT_RATE cycles while the key stays held and en stays 1.
//
// Parameters
//   N_KEYS          number of key channels
//   DEBOUNCE_CYCLES cycles a synchronized level must stay changed (>= 2)
//   REPEAT_DELAY    press pulse to first repeat pulse (autorepeat only)
//   REPEAT_RATE     spacing of further repeat pulses (autorepeat only)
//
// Ports
//   clk       board clock; all state changes on its rising edge
//   reset     asynchronous, active-high reset
//   en        pulse enable; 0 forces pulse and released to 0
//   key_n     raw asynchronous key levels, 0 = pressed
//   pressed   debounced level, 1 = held
//   pulse     one-cycle strobe on accepted press (and on repeats)
//   released  one-cycle strobe on accepted release
// ---------------------------------------------------------------------------
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] pulse,
    output logic [N_KEYS-1:0] released
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1; it is cleared
    // on terminal count, so it can never wrap.
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity: an illegal set shows up as this named block in the
    // elaborated hierarchy, which is easy to spot in any netlist viewer.
    localparam bit PARAMS_LEGAL = (N_KEYS >= 1) && (DEBOUNCE_CYCLES >= 2) &&
                                  (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
    generate
        if (!PARAMS_LEGAL) begin : g_illegal_parameters
        end
    endgenerate

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic [DB_W-1:0] db_cnt_reg;
            logic            level_reg;      // debounced level, 1 = held
            logic            press_ev_reg;   // accepted press, already en-gated
            logic            rel_ev_reg;     // accepted release, already en-gated
            logic            key_down;

            // Synchronized level in "held" polarity.
            assign key_down = ~sync2_reg;

            // Synchronizer and debounce. The synchronizer resets to the
            // released level so a key held through reset is re-debounced.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    db_cnt_reg   <= '0;
                    level_reg    <= 1'b0;
                    press_ev_reg <= 1'b0;
                    rel_ev_reg   <= 1'b0;
                end else begin
                    sync1_reg    <= key_n[gi];
                    sync2_reg    <= sync1_reg;
                    press_ev_reg <= 1'b0;
                    rel_ev_reg   <= 1'b0;
                    if (key_down == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        // DEBOUNCE_CYCLES consecutive disagreeing samples:
                        // accept the new level. The strobe registers line up
                        // with the first cycle in which the new level shows.
                        level_reg    <= key_down;
                        db_cnt_reg   <= '0;
                        press_ev_reg <= en & key_down;
                        rel_ev_reg   <= en & ~key_down;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign pressed[gi]  = level_reg;
            // Also gated by the live en so the strobes vanish as soon as en drops.
            assign released[gi] = en & rel_ev_reg;

`ifdef KEY_AUTOREPEAT_EN
            rpt_state_t       rpt_state_reg;
            rpt_state_t       rpt_state_next;
            logic [RPT_W-1:0] rpt_cnt_reg;
            logic [RPT_W-1:0] rpt_cnt_next;
            logic             rpt_fire;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rpt_state_reg <= RPT_IDLE;
                    rpt_cnt_reg   <= '0;
                end else begin
                    rpt_state_reg <= rpt_state_next;
                    rpt_cnt_reg   <= rpt_cnt_next;
                end
            end

            // The press pulse cycle counts as offset 0; the counter holds
            // (offset - 1) while in DELAY, so the first repeat fires at offset
            // REPEAT_DELAY and later ones every REPEAT_RATE cycles.
            always_comb begin
                rpt_state_next = rpt_state_reg;
                rpt_cnt_next   = rpt_cnt_reg;
                rpt_fire       = 1'b0;
                if (!level_reg || !en) begin
                    // Release or disable cancels repeating in this very cycle.
                    rpt_state_next = RPT_IDLE;
                    rpt_cnt_next   = '0;
                end else begin
                    case (rpt_state_reg)
                        RPT_IDLE: begin
                            if (press_ev_reg) begin
                                rpt_state_next = RPT_DELAY;
                                rpt_cnt_next   = '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt_reg == RPT_DELAY_LAST) begin
                                rpt_fire       = 1'b1;
                                rpt_state_next = RPT_REPEAT;
                                rpt_cnt_next   = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt_reg == RPT_RATE_LAST) begin
                                rpt_fire     = 1'b1;
                                rpt_cnt_next = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            rpt_state_next = RPT_IDLE;
                            rpt_cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign pulse[gi] = en & (press_ev_reg | rpt_fire);
`else
            assign pulse[gi] = en & press_ev_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3, N_KEYS=4. Directed scenarios check the
// documented latencies with constants; a randomized phase compares every
// cycle against a behavioural model that works on the raw sample stream
// (two-edge sampling lag, run length of disagreeing samples, age since press).
// Build with +define+KEY_AUTOREPEAT_EN to exercise the repeat feature.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [NK-1:0] key_n;
    logic [NK-1:0] pressed;
    logic [NK-1:0] pulse;
    logic [NK-1:0] released;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .key_n   (key_n),
        .pressed (pressed),
        .pulse   (pulse),
        .released(released)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [NK-1:0] m_hist0;     // raw sample taken at the latest edge
    logic [NK-1:0] m_hist1;     // raw sample taken one edge earlier
    logic [NK-1:0] m_pressed;
    logic [NK-1:0] m_pulse;
    logic [NK-1:0] m_released;
    int            m_run[NK];   // consecutive samples disagreeing with level
    bit            m_active[NK];
    int            m_age[NK];   // cycles since the press pulse

    task automatic model_reset();
        m_hist0    = '1;
        m_hist1    = '1;
        m_pressed  = '0;
        m_pulse    = '0;
        m_released = '0;
        for (int i = 0; i < NK; i++) begin
            m_run[i]    = 0;
            m_active[i] = 1'b0;
            m_age[i]    = 0;
        end
    endtask

    // Advance one clock edge, update the model from the inputs in force at
    // that edge, and return 1 ns later (outputs are sampled there).
    task automatic step();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NK; i++) begin
                bit p_down;
                p_down     = ~m_hist1[i];   // the sample a decision sees is two edges old
                m_hist1[i] = m_hist0[i];
                m_hist0[i] = key_n[i];
                m_pulse[i]    = 1'b0;
                m_released[i] = 1'b0;
                if (p_down == m_pressed[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_pressed[i] = p_down;
                        m_run[i]     = 0;
                        if (en) begin
                            if (p_down) m_pulse[i] = 1'b1;
                            else        m_released[i] = 1'b1;
                        end
                    end
                end
`ifdef KEY_AUTOREPEAT_EN
                if (!m_pressed[i] || !en) begin
                    m_active[i] = 1'b0;
                end else if (m_pulse[i]) begin
                    m_active[i] = 1'b1;
                    m_age[i]    = 0;
                end else if (m_active[i]) begin
                    m_age[i]++;
                    if (m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0)
                        m_pulse[i] = 1'b1;
                end
`endif
            end
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        key_n = '1;
        model_reset();
        #1;
        checks++;
        if ({pressed, pulse, released} !== '0)
            $display("FAIL reset_async: got %b required 0", {pressed, pulse, released});
        repeat (3) step();
        checks++;
        if ({pressed, pulse, released} !== '0)
            $display("FAIL reset_held: got %b required 0", {pressed, pulse, released});
        #2 reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({pressed, pulse, released} !== '0) begin
                errors++;
                $display("FAIL idle_keys cycle %0d: got %b required 0", k, {pressed, pulse, released});
            end
        end
        $display("test_reset: 20 idle cycles after reset");
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        key_n[0] = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 3) key_n[0] = 1'b1;
            if (pressed[0] !== 1'b0 || pulse[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_3_samples: %0d cycles with pressed/pulse set, required 0", bad);
        end
        $display("test_glitch: 3-sample low on key 0 applied");
    endtask

    task automatic test_press();
        int rise, npulse, pedge;
        rise = 0; npulse = 0; pedge = 0;
        key_n[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (pressed[0] === 1'b1 && rise == 0) rise = k;
            if (pulse[0] === 1'b1) begin
                npulse++;
                pedge = k;
            end
        end
        checks++;
        if (rise != 6) begin
            errors++;
            $display("FAIL press_latency: pressed rose after edge %0d, required 6", rise);
        end
        checks++;
        if (npulse != 1 || pedge != 6) begin
            errors++;
            $display("FAIL press_pulse: %0d pulses, last at edge %0d, required 1 at edge 6", npulse, pedge);
        end
        $display("test_press: key 0 pressed, rise edge %0d, pulses %0d", rise, npulse);
    endtask

    task automatic test_release();
        int redge, nrel;
        redge = 0; nrel = 0;
        repeat (27) step();
        key_n[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (released[0] === 1'b1) begin
                nrel++;
                if (redge == 0) redge = k;
            end
        end
        checks++;
        if (redge != 6 || nrel != 1) begin
            errors++;
            $display("FAIL release_strobe: %0d strobes, first at edge %0d, required 1 at edge 6", nrel, redge);
        end
        checks++;
        if (pressed[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_level: pressed[0]=%b required 0", pressed[0]);
        end
        $display("test_release: key 0 released, strobe edge %0d", redge);
    endtask

    task automatic test_simultaneous();
        logic [NK-1:0] obs_pulse, obs_pressed, any_pulse, any_rel;
        bit seen;
        seen = 1'b0;
        obs_pulse = '0;
        obs_pressed = '0;
        repeat (4) step();
        key_n = 4'b0101;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (!seen && pressed !== '0) begin
                seen        = 1'b1;
                obs_pulse   = pulse;
                obs_pressed = pressed;
            end
        end
        checks++;
        if (obs_pulse !== 4'b1010 || obs_pressed !== 4'b1010) begin
            errors++;
            $display("FAIL simultaneous_en1: pulse=%b pressed=%b required 1010/1010", obs_pulse, obs_pressed);
        end
        key_n = '1;
        repeat (10) step();

        // Same stimulus with en low: levels track, strobes stay silent.
        en = 1'b0;
        any_pulse = '0;
        key_n = 4'b0101;
        for (int k = 1; k <= 12; k++) begin
            step();
            any_pulse |= pulse;
        end
        checks++;
        if (any_pulse !== '0 || pressed !== 4'b1010) begin
            errors++;
            $display("FAIL simultaneous_en0: pulse seen=%b pressed=%b required 0000/1010", any_pulse, pressed);
        end
        key_n = '1;
        any_rel = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            any_rel |= released;
        end
        checks++;
        if (any_rel !== '0 || pressed !== '0) begin
            errors++;
            $display("FAIL release_en0: released seen=%b pressed=%b required 0000/0000", any_rel, pressed);
        end

        // Press accepted while disabled, then enable: no late pulse.
        key_n[1] = 1'b0;
        repeat (10) step();
        en = 1'b1;
        any_pulse = '0;
        for (int k = 1; k <= 15; k++) begin
            step();
            any_pulse |= pulse;
        end
        checks++;
        if (any_pulse !== '0) begin
            errors++;
            $display("FAIL late_pulse_after_en: pulse seen=%b required 0000", any_pulse);
        end
        key_n[1] = 1'b1;
        repeat (10) step();
        $display("test_simultaneous: keys 1,3 pulse=%b", obs_pulse);
    endtask

`ifdef KEY_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic [30:0] obs, exp_v;
        int offs[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
        int found, late, fall;
        bit rel_seen;
        found = 0; late = 0; fall = 0; rel_seen = 1'b0;
        exp_v = '0;
        foreach (offs[j]) exp_v[offs[j]] = 1'b1;
        obs = '0;
        key_n[2] = 1'b0;
        for (int k = 1; k <= 12 && found == 0; k++) begin
            step();
            if (pulse[2] === 1'b1) found = k;
        end
        checks++;
        if (found != 6) begin
            errors++;
            $display("FAIL repeat_first: first pulse at edge %0d, required 6", found);
        end
        obs[0] = (found != 0);
        for (int off = 1; off <= 30; off++) begin
            step();
            obs[off] = pulse[2];
        end
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL repeat_offsets: got %b required %b", obs, exp_v);
        end
        key_n[2] = 1'b1;
        for (int k = 1; k <= 12 && fall == 0; k++) begin
            step();
            if (pressed[2] === 1'b0) begin
                fall = k;
                if (pulse[2] !== 1'b0) late++;
                if (released[2] === 1'b1) rel_seen = 1'b1;
            end
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            if (pulse[2] !== 1'b0) late++;
        end
        checks++;
        if (fall == 0 || late != 0 || !rel_seen) begin
            errors++;
            $display("FAIL repeat_release: fall edge %0d, late pulses %0d, strobe %0b, required >0/0/1", fall, late, rel_seen);
        end
        $display("test_autorepeat: pulse offsets %b", obs);
    endtask
`else
    task automatic test_hold_single();
        int npulse;
        npulse = 0;
        key_n[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (pulse[2] === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("FAIL hold_single: %0d pulses, required 1", npulse);
        end
        key_n[2] = 1'b1;
        repeat (10) step();
        $display("test_hold_single: key 2 held 40 cycles, pulses %0d", npulse);
    endtask
`endif

    task automatic test_reset_mid_press();
        int pedge, npulse;
        pedge = 0; npulse = 0;
        key_n[0] = 1'b0;
        repeat (8) step();
        checks++;
        if (pressed[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_press_setup: pressed[0]=%b required 1", pressed[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pressed, pulse, released} !== '0) begin
            errors++;
            $display("FAIL mid_press_reset: got %b required 0", {pressed, pulse, released});
        end
        step();
        step();
        #2 reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (pulse[0] === 1'b1) begin
                npulse++;
                if (pedge == 0) pedge = k;
            end
        end
        checks++;
        if (npulse != 1 || pedge != 6) begin
            errors++;
            $display("FAIL mid_press_repulse: %0d pulses, first at edge %0d, required 1 at edge 6", npulse, pedge);
        end
        key_n[0] = 1'b1;
        repeat (10) step();
        $display("test_reset_mid_press: fresh pulse at edge %0d", pedge);
    endtask

    task automatic test_random();
        int runlen[NK];
        en = 1'b1;
        key_n = '1;
        repeat (10) step();
        for (int i = 0; i < NK; i++) runlen[i] = 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NK; i++) begin
                runlen[i]--;
                if (runlen[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    runlen[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40))
                                                            : int'($urandom_range(1, 6));
                end
            end
            if ($urandom_range(0, 31) == 0) en = ~en;
            step();
            checks++;
            if (pressed !== m_pressed) begin
                errors++;
                $display("FAIL rand_pressed cycle %0d: got %b required %b", cyc, pressed, m_pressed);
            end
            checks++;
            if (pulse !== m_pulse) begin
                errors++;
                $display("FAIL rand_pulse cycle %0d: got %b required %b", cyc, pulse, m_pulse);
            end
            checks++;
            if (released !== m_released) begin
                errors++;
                $display("FAIL rand_released cycle %0d: got %b required %b", cyc, released, m_released);
            end
            if (m_pulse != '0 || m_released != '0)
                $display("rand cycle %0d: en=%b pressed=%b pulse=%b released=%b",
                         cyc, en, m_pressed, m_pulse, m_released);
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_simultaneous();
`ifdef KEY_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_hold_single();
`endif
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: the scenarios are bounded, this only catches a stuck clock.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-side counterpart to the 7-segment/LED display path. It turns raw, bouncing, active-low push-buttons (board KEY pins) into clean per-key press/release pulses and debounced levels.
- Sits between the board KEY inputs and the control FSM, replacing direct `~KEY[n]` wiring. The control logic then sees exactly one single-cycle pulse per physical press, optionally with hold-to-repeat.
- Runs on the 50 MHz board clock. Keys are independent, identical channels.

Parameters:
- N_KEYS, 4, number of key channels.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized level must stay changed before it is accepted (20 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first auto-repeat pulse. Used only with KEY_AUTOREPEAT_EN.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses. Used only with KEY_AUTOREPEAT_EN.

Ports:
- clk  input  1  board clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  pulse enable; 0 suppresses pulse/released outputs.
- key_n  input  N_KEYS  raw asynchronous key levels, 0 = pressed.
- pressed  output  N_KEYS  debounced level, 1 = held.
- pulse  output  N_KEYS  one-cycle strobe on accepted press (and repeats).
- released  output  N_KEYS  one-cycle strobe on accepted release.

Behaviour:
- Reset (async, active-high):
  - sync flops = 1 and stable level = released;
  - counters = 0;
  - pressed, pulse, released = 0;
  - repeat FSM = IDLE.
- Synchronizer: 2 flops per key; stage 2 output is `s[i]`. The raw key_n never reaches logic directly.
- Debounce, per key, with counter width $clog2(DEBOUNCE_CYCLES):
  - if `s[i]` == current stable level, counter ← 0;
  - otherwise, if counter == DEBOUNCE_CYCLES-1, the stable level toggles and counter ← 0;
  - otherwise counter ← counter+1.
- Latency: counting the first edge that samples the new key_n level as edge 1, pressed changes after edge DEBOUNCE_CYCLES+2.
- Glitch rejection: a change held for ≤ DEBOUNCE_CYCLES-1 samples is rejected. A change held for ≥ DEBOUNCE_CYCLES samples is accepted.
- pulse[i] = 1 for exactly the cycle in which pressed[i] first reads 1, gated by en.
- released[i] = 1 for exactly the cycle in which pressed[i] first reads 0, gated by en.
- en = 0:
  - debounce and pressed still track the keys;
  - pulse and released are forced to 0;
  - a press accepted while en = 0 produces no pulse later.
- Keys are fully independent. Simultaneous presses on several keys give simultaneous pulses in the same cycle.
- Counters saturate by construction; they never wrap because they reset on terminal count.
- Reset mid-press: all outputs drop to 0 immediately. If the key is still held after reset deasserts, it is re-debounced from scratch and produces one fresh pulse after DEBOUNCE_CYCLES+2 edges.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined: per-key repeat FSM with states IDLE, DELAY and REPEAT, plus a repeat counter.
  - IDLE → DELAY on the press pulse; counter ← 0.
  - In DELAY, when counter reaches REPEAT_DELAY-1: pulse, go to REPEAT, counter ← 0.
  - In REPEAT, pulse every REPEAT_RATE cycles.
  - Any state → IDLE when pressed = 0 or en = 0 (same cycle; no further pulses).
  - Release always produces the released strobe, independent of repeat state.
- Undefined: no repeat FSM or counters are synthesized. A hold produces exactly one pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_KEYS=4):
- Reset, then key_n=4'hF for 20 cycles → pressed=0, pulse=0, released=0 throughout.
- key_n[0] low for 3 cycles, then high → no pulse, pressed[0] stays 0.
- key_n[0] low and held, starting at edge 1 → pressed[0] rises after edge 6; pulse[0]=1 for that single cycle only.
- Release key_n[0] after 30 cycles → released[0] single-cycle strobe 6 edges later; pressed[0]=0.
- key_n[1] and key_n[3] fall on the same edge with en=1 → pulse=4'b1010 in one cycle.
- With en=0 the same stimulus gives pulse=0 and pressed=4'b1010.
- KEY_AUTOREPEAT_EN defined, key_n[2] held for 30 cycles after acceptance:
  - pulses at cycle offsets 0, 10, 13, 16, 19, 22, 25, 28;
  - on release, no pulse after the release is accepted.
- Assert reset while key_n[0] is held and pressed[0]=1 → all outputs 0 immediately. After deassertion, exactly one pulse after 6 edges.
